// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiters.
// Requester count and index width are fixed here so every arbiter agrees on them.
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      return NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first set req bit found
// starting at ptr and wrapping around wins.
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [IDX_W-1:0]   pick_idx
);

   logic [IDX_W-1:0] w_cand;

   // Walk the rotation from lowest to highest priority so the last hit wins.
   always_comb begin
      pick_idx = '0;
      w_cand   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_cand = ptr + IDX_W'(k);
         if (req[w_cand]) begin
            pick_idx = w_cand;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for the shared encode/decode datapath: registered
// one-hot grant held until release or until the MAX_HOLD limit revokes it.
module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid,
   output logic               timeout
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 1) ? HOLD_W'(MAX_HOLD - 1) : '0;

   arb_state_t        r_state;
   logic [IDX_W-1:0]  r_ptr;
   logic [HOLD_W-1:0] r_holdCnt;
   logic [NUM_REQ-1:0] r_gnt;
   logic [IDX_W-1:0]  r_gntIdx;
   logic              r_gntValid;
   logic              r_timeout;

   logic [IDX_W-1:0]  w_searchPtr;
   logic              w_any;
   logic [IDX_W-1:0]  w_pickIdx;
   logic              w_ownerReq;
   logic              w_holdExpired;
   logic              w_release;

   // On a release the search starts just past the owner, so the owner
   // itself remains a candidate but at the lowest priority.
   assign w_searchPtr   = (r_state == BUSY) ? r_gntIdx + IDX_W'(1) : r_ptr;
   assign w_ownerReq    = |(req & r_gnt);
   assign w_holdExpired = (MAX_HOLD != 0) && (r_holdCnt == HOLD_LAST);
   assign w_release     = (r_state == BUSY) && (!w_ownerReq || w_holdExpired);

   rr_pick u_pick (
      .req      (req),
      .ptr      (w_searchPtr),
      .any      (w_any),
      .pick_idx (w_pickIdx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_holdCnt  <= '0;
         r_gnt      <= '0;
         r_gntIdx   <= '0;
         r_gntValid <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state    <= BUSY;
                  r_gnt      <= idx_to_onehot(w_pickIdx);
                  r_gntIdx   <= w_pickIdx;
                  r_gntValid <= 1'b1;
                  r_holdCnt  <= '0;
               end
            end
            BUSY: begin
               if (w_release) begin
                  r_ptr     <= r_gntIdx + IDX_W'(1);
                  r_timeout <= w_ownerReq && w_holdExpired;
                  r_holdCnt <= '0;
                  if (w_any) begin
                     r_gnt      <= idx_to_onehot(w_pickIdx);
                     r_gntIdx   <= w_pickIdx;
                     r_gntValid <= 1'b1;
                  end else begin
                     r_state    <= IDLE;
                     r_gnt      <= '0;
                     r_gntIdx   <= '0;
                     r_gntValid <= 1'b0;
                  end
               end else if (r_holdCnt != HOLD_LAST) begin
                  r_holdCnt <= r_holdCnt + HOLD_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_idx   = r_gntIdx;
   assign gnt_valid = r_gntValid;
   assign timeout   = r_timeout;

endmodule
